// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus addresses,
// STATUS bit layout and the transmit FSM state type.
package uart_tx_mmio_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [15:0] UART_DATA_ADDR   = 16'hE000;
  localparam logic [15:0] UART_STATUS_ADDR = 16'hE001;

  localparam int UART_ST_BUSY  = 0;
  localparam int UART_ST_FULL  = 1;
  localparam int UART_ST_EMPTY = 2;
  localparam int UART_ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  function automatic logic [DATA_WIDTH-1:0] uart_status(input logic ovf, input logic empty,
                                                        input logic full, input logic busy);
    logic [DATA_WIDTH-1:0] s;
    s                = '0;
    s[UART_ST_BUSY]  = busy;
    s[UART_ST_FULL]  = full;
    s[UART_ST_EMPTY] = empty;
    s[UART_ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes when full and pops when
// empty are ignored, so the caller may strobe freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push && reset) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU-bus UART transmitter: DATA/STATUS decode, sticky overflow and the 8N1
// shift FSM fed from a small byte FIFO.
//   state | meaning
//   IDLE  | line high, pops the FIFO head when data is waiting
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | data bits LSB first, CLKS_PER_BIT cycles each
//   STOP  | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_i,
  input  logic                  reg_sel_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  tx_o,
  output logic                  tx_idle_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  uart_tx_state_t        r_state;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_ovf;

  logic                  w_wr_data;
  logic                  w_rd_status;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_busy;
  logic                  w_clk_tc;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_status;

  assign w_wr_data   = cs_i & we_i & ~reg_sel_i;
  assign w_rd_status = cs_i & re_i & reg_sel_i;
  assign w_push      = w_wr_data & ~w_full;
  assign w_busy      = (r_state != IDLE);
  assign w_pop       = ~w_busy & ~w_empty;
  assign w_clk_tc    = (r_clk_cnt == CNT_TC);

  assign w_status  = uart_status(r_ovf, w_empty, w_full, w_busy);
  assign data_o    = (cs_i && reg_sel_i) ? w_status : '0;
  assign tx_o      = r_tx;
  assign tx_idle_o = w_empty & ~w_busy;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data_i),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // A dropped write on the same edge as a STATUS read keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_wr_data && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_rd_status) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_clk_tc) begin
            r_clk_cnt <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_clk_tc) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_clk_tc) begin
            r_clk_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
